// File: rtl/regfile_write_scheduler_pkg.sv
// Shared types and constants for the register-file write scheduler.
// Widths, source IDs and the writeback-entry record.
package regfile_write_scheduler_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic                  age;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Writeback request, register-file write and hazard-check bundle.
// The master side belongs to the producers, slave to the scheduler.
interface regfile_write_scheduler_if
  import regfile_write_scheduler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              rf_write_en;
  logic [ADDR_W-1:0] rf_write_address;
  logic [DATA_W-1:0] rf_write_data;
  logic [ADDR_W-1:0] rd_chk_addr_0;
  logic [ADDR_W-1:0] rd_chk_addr_1;
  logic              hazard_0;
  logic              hazard_1;
  logic              busy;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output rd_chk_addr_0, rd_chk_addr_1,
    input  alu_ready, mem_ready,
    input  rf_write_en, rf_write_address,
    input  rf_write_data,
    input  hazard_0, hazard_1, busy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  rd_chk_addr_0, rd_chk_addr_1,
    output alu_ready, mem_ready,
    output rf_write_en, rf_write_address,
    output rf_write_data,
    output hazard_0, hazard_1, busy
  );

endinterface

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding register with ready and
// hazard address compare.
module wb_hold_slot #(
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 32,
  parameter bit ZERO_WRITE_DROP = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_age,
  input  logic              i_grant,
  input  logic              i_other_grant,
  input  logic [ADDR_W-1:0] i_chk_addr_0,
  input  logic [ADDR_W-1:0] i_chk_addr_1,
  output logic              o_ready,
  output logic              o_held,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_age,
  output logic              o_hit_0,
  output logic              o_hit_1
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_age;
  logic              w_take;
  logic              w_live;

  assign w_take = i_valid & ~r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_age   <= 1'b0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
      r_age   <= i_age;
    end else begin
      if (i_grant)
        r_valid <= 1'b0;
      // once the other entry leaves, this one is oldest
      if (i_other_grant)
        r_age <= 1'b0;
    end
  end

  // dropped zero-address writes never reach the file
  assign w_live = r_valid &
    ~(ZERO_WRITE_DROP && (r_addr == '0));

  assign o_ready = ~r_valid;
  assign o_held  = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_age   = r_age;
  assign o_hit_0 = w_live && (r_addr == i_chk_addr_0);
  assign o_hit_1 = w_live && (r_addr == i_chk_addr_1);

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between ALU and load
// writeback: round-robin, oldest-first on same address.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter bit ZERO_WRITE_DROP = 1'b0
) (
  input logic                      clk,
  input logic                      rst,
  regfile_write_scheduler_if.slave bus
);

  logic              w_alu_held, w_mem_held;
  logic              w_alu_age, w_mem_age;
  logic              w_alu_cap_age, w_mem_cap_age;
  logic              w_alu_take;
  logic              w_alu_hit_0, w_alu_hit_1;
  logic              w_mem_hit_0, w_mem_hit_1;
  logic [ADDR_W-1:0] w_alu_addr, w_mem_addr;
  logic [DATA_W-1:0] w_alu_data, w_mem_data;
  logic              w_gnt_alu, w_gnt_mem, w_gnt_any;
  logic              w_both_same, w_both_diff;
  logic              w_only_alu, w_only_mem;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_drop, w_issue;

  logic              r_ptr;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;

  assign w_alu_take = bus.alu_valid & bus.alu_ready;

  // age=1 marks the younger entry; ALU wins same-edge ties
  assign w_alu_cap_age = w_mem_held & ~w_gnt_mem;
  assign w_mem_cap_age = (w_alu_held & ~w_gnt_alu)
                       | w_alu_take;

  wb_hold_slot #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ZERO_WRITE_DROP(ZERO_WRITE_DROP)
  ) u_alu_slot (
    .clk(clk), .rst(rst),
    .i_valid(bus.alu_valid),
    .i_addr(bus.alu_addr),
    .i_data(bus.alu_data),
    .i_age(w_alu_cap_age),
    .i_grant(w_gnt_alu),
    .i_other_grant(w_gnt_mem),
    .i_chk_addr_0(bus.rd_chk_addr_0),
    .i_chk_addr_1(bus.rd_chk_addr_1),
    .o_ready(bus.alu_ready),
    .o_held(w_alu_held),
    .o_addr(w_alu_addr),
    .o_data(w_alu_data),
    .o_age(w_alu_age),
    .o_hit_0(w_alu_hit_0),
    .o_hit_1(w_alu_hit_1)
  );

  wb_hold_slot #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ZERO_WRITE_DROP(ZERO_WRITE_DROP)
  ) u_mem_slot (
    .clk(clk), .rst(rst),
    .i_valid(bus.mem_valid),
    .i_addr(bus.mem_addr),
    .i_data(bus.mem_data),
    .i_age(w_mem_cap_age),
    .i_grant(w_gnt_mem),
    .i_other_grant(w_gnt_alu),
    .i_chk_addr_0(bus.rd_chk_addr_0),
    .i_chk_addr_1(bus.rd_chk_addr_1),
    .o_ready(bus.mem_ready),
    .o_held(w_mem_held),
    .o_addr(w_mem_addr),
    .o_data(w_mem_data),
    .o_age(w_mem_age),
    .o_hit_0(w_mem_hit_0),
    .o_hit_1(w_mem_hit_1)
  );

  assign w_both_same = w_alu_held & w_mem_held
                     & (w_alu_addr == w_mem_addr);
  assign w_both_diff = w_alu_held & w_mem_held
                     & (w_alu_addr != w_mem_addr);
  assign w_only_alu  = w_alu_held & ~w_mem_held;
  assign w_only_mem  = w_mem_held & ~w_alu_held;

  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_mem = 1'b0;
    unique case (1'b1)
      w_both_same: begin
        w_gnt_alu = ~w_alu_age;
        w_gnt_mem = w_alu_age;
      end
      w_both_diff: begin
        w_gnt_alu = (r_ptr == SRC_ALU);
        w_gnt_mem = (r_ptr == SRC_MEM);
      end
      w_only_alu: w_gnt_alu = 1'b1;
      w_only_mem: w_gnt_mem = 1'b1;
      default: ;
    endcase
  end

  assign w_gnt_any  = w_gnt_alu | w_gnt_mem;
  assign w_gnt_addr = w_gnt_mem ? w_mem_addr : w_alu_addr;
  assign w_gnt_data = w_gnt_mem ? w_mem_data : w_alu_data;
  assign w_drop     = ZERO_WRITE_DROP && (w_gnt_addr == '0);
  assign w_issue    = w_gnt_any & ~w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= SRC_ALU;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_issue;
      if (w_issue) begin
        r_out_addr <= w_gnt_addr;
        r_out_data <= w_gnt_data;
      end
      if (w_gnt_any)
        r_ptr <= w_gnt_mem ? SRC_ALU : SRC_MEM;
    end
  end

  assign bus.rf_write_en      = r_out_valid;
  assign bus.rf_write_address = r_out_addr;
  assign bus.rf_write_data    = r_out_data;

  assign bus.hazard_0 = w_alu_hit_0 | w_mem_hit_0
    | (r_out_valid && (r_out_addr == bus.rd_chk_addr_0));
  assign bus.hazard_1 = w_alu_hit_1 | w_mem_hit_1
    | (r_out_valid && (r_out_addr == bus.rd_chk_addr_1));

  assign bus.busy = w_alu_held | w_mem_held | r_out_valid;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench: a queue-based model predicts every write and
// the per-cycle ready/busy/hazard flags for drop=0 and drop=1.
module tb_regfile_write_scheduler;
  import regfile_write_scheduler_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            dly;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_write_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus0();
  regfile_write_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus1();

  assign bus1.alu_valid     = bus0.alu_valid;
  assign bus1.alu_addr      = bus0.alu_addr;
  assign bus1.alu_data      = bus0.alu_data;
  assign bus1.mem_valid     = bus0.mem_valid;
  assign bus1.mem_addr      = bus0.mem_addr;
  assign bus1.mem_data      = bus0.mem_data;
  assign bus1.rd_chk_addr_0 = bus0.rd_chk_addr_0;
  assign bus1.rd_chk_addr_1 = bus0.rd_chk_addr_1;

  regfile_write_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .ZERO_WRITE_DROP(1'b0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  regfile_write_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .ZERO_WRITE_DROP(1'b1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // reference model: pending entries per source, ordered by
  // capture sequence number; expected writes go to q0/q1
  bit            m_held [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  int            m_seq  [2];
  bit            m_acc  [2];
  int            seq_ctr = 0;
  bit            m_ptr = 1'b0;
  bit            m_out0 = 1'b0;
  bit            m_out1 = 1'b0;
  logic [AW-1:0] m_out_addr = '0;
  wb_entry_t     q0[$];
  wb_entry_t     q1[$];

  always @(posedge clk) begin
    bit        rdy0, rdy1;
    int        g;
    wb_entry_t e;
    m_acc[0] = 1'b0;
    m_acc[1] = 1'b0;
    if (rst) begin
      m_held[0] = 1'b0;
      m_held[1] = 1'b0;
      m_ptr  = 1'b0;
      m_out0 = 1'b0;
      m_out1 = 1'b0;
    end else begin
      rdy0 = !m_held[0];
      rdy1 = !m_held[1];
      g = -1;
      if (m_held[0] && m_held[1]) begin
        if (m_addr[0] == m_addr[1])
          g = (m_seq[0] < m_seq[1]) ? 0 : 1;
        else
          g = m_ptr ? 1 : 0;
      end else if (m_held[0]) g = 0;
      else if (m_held[1]) g = 1;
      m_out0 = 1'b0;
      m_out1 = 1'b0;
      if (g >= 0) begin
        e = '{valid: 1'b1, addr: m_addr[g],
              data: m_data[g], age: 1'b0};
        q0.push_back(e);
        m_out0 = 1'b1;
        m_out_addr = m_addr[g];
        if (m_addr[g] != 0) begin
          q1.push_back(e);
          m_out1 = 1'b1;
        end
        m_held[g] = 1'b0;
        m_ptr = (g == 0);
      end
      if (bus0.alu_valid && rdy0) begin
        m_held[0] = 1'b1;
        m_addr[0] = bus0.alu_addr;
        m_data[0] = bus0.alu_data;
        m_seq[0]  = seq_ctr++;
        m_acc[0]  = 1'b1;
      end
      if (bus0.mem_valid && rdy1) begin
        m_held[1] = 1'b1;
        m_addr[1] = bus0.mem_addr;
        m_data[1] = bus0.mem_data;
        m_seq[1]  = seq_ctr++;
        m_acc[1]  = 1'b1;
      end
    end
  end

  function automatic bit haz(input logic [AW-1:0] a,
                             input bit drop,
                             input bit outv);
    bit h;
    h = outv && (m_out_addr == a);
    for (int s = 0; s < 2; s++)
      if (m_held[s] && m_addr[s] == a && !(drop && a == 0))
        h = 1'b1;
    return h;
  endfunction

  // monitor
  always @(negedge clk) begin
    wb_entry_t e;
    if (mon_en) begin
      chk("alu_ready0", bus0.alu_ready, !m_held[0]);
      chk("mem_ready0", bus0.mem_ready, !m_held[1]);
      chk("alu_ready1", bus1.alu_ready, !m_held[0]);
      chk("mem_ready1", bus1.mem_ready, !m_held[1]);
      chk("busy0", bus0.busy, m_held[0] | m_held[1] | m_out0);
      chk("busy1", bus1.busy, m_held[0] | m_held[1] | m_out1);
      chk("wen0", bus0.rf_write_en, m_out0);
      chk("wen1", bus1.rf_write_en, m_out1);
      chk("haz0_d0", bus0.hazard_0,
          haz(bus0.rd_chk_addr_0, 1'b0, m_out0));
      chk("haz1_d0", bus0.hazard_1,
          haz(bus0.rd_chk_addr_1, 1'b0, m_out0));
      chk("haz0_d1", bus1.hazard_0,
          haz(bus0.rd_chk_addr_0, 1'b1, m_out1));
      chk("haz1_d1", bus1.hazard_1,
          haz(bus0.rd_chk_addr_1, 1'b1, m_out1));
      if (bus0.rf_write_en === 1'b1) begin
        if (q0.size() == 0) chk("wr0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          chk("wr0_addr", bus0.rf_write_address, e.addr);
          chk("wr0_data", bus0.rf_write_data, e.data);
        end
      end
      if (bus1.rf_write_en === 1'b1) begin
        if (q1.size() == 0) chk("wr1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          chk("wr1_addr", bus1.rf_write_address, e.addr);
          chk("wr1_data", bus1.rf_write_data, e.data);
        end
      end
    end
  end

  // driver: each source holds its request until accepted
  item_t         sq0[$];
  item_t         sq1[$];
  logic [AW-1:0] pool [8] = '{0, 1, 2, 4, 5, 8, 16, 31};

  task automatic drive_src(input int s);
    item_t it;
    bit v;
    v = (s == 0) ? bus0.alu_valid : bus0.mem_valid;
    if (rst) v = 1'b0;
    else if (v && m_acc[s]) v = 1'b0;
    if (!v && !rst) begin
      if (s == 0 && sq0.size() > 0) begin
        if (sq0[0].dly > 0) sq0[0].dly--;
        else begin
          it = sq0.pop_front();
          bus0.alu_addr = it.a;
          bus0.alu_data = it.d;
          v = 1'b1;
        end
      end
      if (s == 1 && sq1.size() > 0) begin
        if (sq1[0].dly > 0) sq1[0].dly--;
        else begin
          it = sq1.pop_front();
          bus0.mem_addr = it.a;
          bus0.mem_data = it.d;
          v = 1'b1;
        end
      end
    end
    if (s == 0) bus0.alu_valid = v;
    else bus0.mem_valid = v;
  endtask

  initial begin
    bus0.alu_valid = 1'b0;
    bus0.alu_addr  = '0;
    bus0.alu_data  = '0;
    bus0.mem_valid = 1'b0;
    bus0.mem_addr  = '0;
    bus0.mem_data  = '0;
    bus0.rd_chk_addr_0 = '0;
    bus0.rd_chk_addr_1 = '0;
    forever begin
      @(posedge clk);
      #2;
      drive_src(0);
      drive_src(1);
      bus0.rd_chk_addr_0 = pool[$urandom_range(0, 7)];
      bus0.rd_chk_addr_1 = pool[$urandom_range(0, 7)];
    end
  end

  function automatic item_t mk(input logic [AW-1:0] a,
                               input logic [DW-1:0] d,
                               input int dly);
    item_t it;
    it.a = a;
    it.d = d;
    it.dly = dly;
    return it;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sq0.size() > 0 || sq1.size() > 0 ||
            bus0.alu_valid || bus0.mem_valid ||
            m_held[0] || m_held[1] || m_out0) &&
           n < budget) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (n >= budget) chk("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #3;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_addr0", bus0.rf_write_address, 0);
    chk("rst_data0", bus0.rf_write_data, 0);

    // simultaneous, different addresses, pointer at reset
    sq0.push_back(mk(1, 7, 0));
    sq1.push_back(mk(5, 9, 0));
    wait_idle(50);
    // single ALU write
    sq0.push_back(mk(4, 32'h0000_000A, 0));
    wait_idle(50);
    // same address, MEM captured one edge earlier
    sq1.push_back(mk(16, 32'h11, 0));
    sq0.push_back(mk(16, 32'h22, 1));
    wait_idle(50);
    // ALU backpressure
    sq0.push_back(mk(3, 1, 0));
    sq0.push_back(mk(3, 2, 0));
    sq0.push_back(mk(3, 3, 0));
    wait_idle(50);
    // zero-address load write
    sq1.push_back(mk(0, 32'h55, 0));
    wait_idle(50);
    // simultaneous, same address
    sq0.push_back(mk(2, 32'hA1, 0));
    sq1.push_back(mk(2, 32'hB2, 0));
    wait_idle(50);

    // reset while a write sits in the output stage
    sq0.push_back(mk(8, 32'h88, 0));
    n = 0;
    while (!(m_out0 && m_out_addr == 8) && n < 20) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (n >= 20) chk("rst_mid_timeout", 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    chk("midrst_addr0", bus0.rf_write_address, 0);
    chk("midrst_data0", bus0.rf_write_data, 0);
    chk("midrst_busy0", bus0.busy, 0);
    repeat (5) @(posedge clk);
    #3;

    for (int i = 0; i < 120; i++) begin
      sq0.push_back(mk(pool[$urandom_range(0, 7)],
                       $urandom, $urandom_range(0, 2)));
      sq1.push_back(mk(pool[$urandom_range(0, 7)],
                       $urandom, $urandom_range(0, 2)));
    end
    wait_idle(3000);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Shares the register file's single write port between the two writeback sources of the multi-cycle processor: ALU result and memory load.
- Each source has a one-entry holding register.
- Arbitration is round-robin, with program-order preservation on same-address conflicts.
- A registered output stage drives rf_write_en, rf_write_address and rf_write_data into the register file.
- Combinational hazard flags let the control FSM stall reads of registers with writes still pending.

Parameters:
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- ZERO_WRITE_DROP, 0: if 1, writes to address 0 are accepted but never issued to the register file (no rf_write_en pulse).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU holding register empty.
- mem_valid  in  1  load writeback request.
- mem_addr  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  MEM holding register empty.
- rf_write_en  out  1  register-file write strobe, one cycle per write.
- rf_write_address  out  ADDR_W  register-file write address.
- rf_write_data  out  DATA_W  register-file write data.
- rd_chk_addr_0  in  ADDR_W  read address 0 to check for hazards.
- rd_chk_addr_1  in  ADDR_W  read address 1 to check for hazards.
- hazard_0  out  1  pending write to rd_chk_addr_0.
- hazard_1  out  1  pending write to rd_chk_addr_1.
- busy  out  1  any holding register or the output stage occupied.

Behaviour:
- Reset:
  - Applies on the clock edge while rst=1 (synchronous).
  - Clears both holding registers, age bit, round-robin pointer (next favours ALU) and output stage.
  - Outputs after reset: rf_write_en=0, rf_write_address=0, rf_write_data=0, alu_ready=1, mem_ready=1, busy=0.
  - Hazard flags are 0 after reset.
  - A reset mid-operation discards held and in-flight writes; no rf_write_en follows.
- Accept:
  - alu_ready = ~alu_held and mem_ready = ~mem_held, both from registered state.
  - A request is captured at the edge where valid & ready; the source's held bit is set.
  - valid while not ready is ignored, not queued; the source must hold its request.
- Arbitration, in the cycle after capture:
  - If only one entry is held, it is granted.
  - If both are held with different addresses: round-robin. The pointer flips to the other source after each grant.
  - If both are held with equal addresses: the older entry is granted, tracked by an age bit set at capture.
  - If both were captured on the same edge, ALU is treated as older.
- Issue:
  - The granted entry is copied into the output stage and its held bit is cleared on the same edge.
  - rf_write_en=1 for exactly one cycle, two cycles after the accept edge.
  - Minimum per-source accept spacing is 2 cycles; the combined port throughput is 1 write per cycle once both sources are loaded.
- ZERO_WRITE_DROP=1 with address 0:
  - The entry is still granted and its held bit cleared.
  - The output stage stays idle, so rf_write_en remains 0.
- Hazards:
  - hazard_k is combinational.
  - hazard_k = 1 if rd_chk_addr_k matches the address of any held entry or of a valid output stage.
  - Dropped zero-address writes raise no hazard while held.
- busy = alu_held | mem_held | rf_write_en.
- Widths:
  - Data and address pass through unmodified.
  - No arithmetic except the single-bit pointer toggle.

Decomposition:
- Shared package holds:
  - ADDR_W and DATA_W defaults.
  - A writeback-entry record: valid, addr, data, age.
  - Source-ID constants: SRC_ALU=0, SRC_MEM=1.
- One sub-module: wb_hold_slot, instantiated twice.
  - Contains the one-entry holding register, ready generation and address compare for hazards.
- Arbitration and the output stage live in the top module.

Test Plan:
1. Single ALU write: alu_valid=1, alu_addr=4, alu_data=0x0000000A at edge N. Required: rf_write_en=1 with address 4 and data 0xA during cycle N+2 only; hazard_0=1 with rd_chk_addr_0=4 during cycles N+1..N+2.
2. Simultaneous requests, different addresses: ALU to addr 1 data 7 and MEM to addr 5 data 9 accepted on the same edge, pointer at reset value. Required: write {1,7} in the first cycle, then {5,9} in the next; busy falls afterwards.
3. Same-address ordering: MEM addr 16 data 0x11 captured one edge before ALU addr 16 data 0x22 (pointer favouring ALU). Required: write order is 0x11 then 0x22; the final register-16 value is 0x22.
4. Backpressure: alu_valid held high with data 1,2,3 changing only on accepted edges. Required: alu_ready toggles 1,0,1,0; three writes spaced 2 cycles apart with data 1,2,3.
5. ZERO_WRITE_DROP=1 and MEM write to addr 0: required alu_ready/mem_ready handshake completes, rf_write_en never asserts, and hazard on addr 0 stays 0.
6. Reset mid-flight: rst=1 at the edge where a write to addr 8 sits in the output stage. Required: the next cycle has rf_write_en=0, busy=0, both readies=1, and no later write occurs.
